// File: rtl/display_interval_timer.sv
// Interval timer for the text-display path: prescaled tick counter with
// one-shot / periodic modes, pause, abort, restart and remaining readout.
module display_interval_timer #(
    parameter int WIDTH         = 16,
    parameter int PRESCALE      = 1,
    parameter int DEFAULT_COUNT = 2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_value,
    output logic             done,
    output logic             busy,
    output logic             expired,
    output logic [WIDTH-1:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;

    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] DEF_P   = WIDTH'(DEFAULT_COUNT);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, expired_q;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            rem_d   = '0;
            presc_d = '0;
        end else if (start) begin
            period_d = (load_value == '0) ? DEF_P : load_value;
            mode_d   = mode;
            rem_d    = (load_value == '0) ? DEF_P : load_value;
            presc_d  = '0;
            state_d  = S_RUN;
        end else if (state_q == S_RUN && enable) begin
            if (presc_q == PRE_MAX) begin
                presc_d = '0;
                if (rem_q > WIDTH'(1)) begin
                    rem_d = rem_q - WIDTH'(1);
                end else begin
                    // terminal tick: reload from latched period or finish
                    done_d = 1'b1;
                    if (mode_q) begin
                        rem_d = period_q;
                    end else begin
                        rem_d   = '0;
                        state_d = S_EXP;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            rem_q     <= '0;
            period_q  <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            busy_q    <= (state_d == S_RUN);
            expired_q <= (state_d == S_EXP);
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign expired   = expired_q;
    assign remaining = rem_q;

endmodule
